dmem_bus: RTL and testbench
===========================

Name: dmem_bus

Overview:
- Data-side memory subsystem sitting directly downstream of the processor's execute/memory stage.
- Consumes the registered `mem_addr`/`mem_oe`/`mem_wdata`/`mem_we` request and returns `mem_rdata`/`mem_valid`, with `mem_ready` as backpressure.
- Decodes each request to an on-chip byte-lane RAM or to an MMIO block holding a TX byte FIFO that drains into an external UART transmitter.

Parameters:
- RAM_AW, 14, byte-address width of the RAM region (RAM size = 2^RAM_AW bytes, word-organised).
- FIFO_AW, 4, log2 of TX FIFO depth (depth = 16).
- MMIO_BASE, 32'h8000_0000, base address of the MMIO region (a 16-byte window).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- mem_addr  in  32  byte address of the request.
- mem_oe  in  4  byte-lane read/access enables; nonzero means a request is present this cycle.
- mem_wdata  in  32  write data, lane-aligned.
- mem_we  in  4  byte-lane write enables; nonzero means a write.
- mem_rdata  out  32  read data, registered.
- mem_valid  out  1  one-cycle pulse: `mem_rdata` is valid for the previous cycle's read.
- mem_ready  out  1  combinational: a request may be presented at the next edge.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO not empty.
- tx_ready  in  1  UART accepts `tx_data` when `tx_valid && tx_ready` at posedge.

Behaviour:
- Request definition: a request is accepted at posedge when `mem_oe != 0`.
  - Read: `mem_we == 0`.
  - Write: `mem_we != 0`, with `mem_oe` covering the same lanes.
- Decode:
  - RAM when `mem_addr < 2^RAM_AW`.
  - MMIO when `mem_addr[31:4] == MMIO_BASE[31:4]`.
  - Anything else is unmapped.
- RAM write: at acceptance edge, byte k is written from `mem_wdata[8k+:8]` iff `mem_we[k]`. Word index = `mem_addr[RAM_AW-1:2]`; `mem_addr[1:0]` is ignored.
- RAM read: `mem_rdata` = full aligned word, with `mem_valid`=1, in the cycle after acceptance (latency 1). A write at edge N followed by a read at edge N+1 returns the new data.
- MMIO registers (offset = `mem_addr[3:2]`):
  - 0 TXDATA (write): pushes `mem_wdata[7:0]` if lane 0 is enabled. Reads return 0.
  - 1 STATUS (read-only): bit0 = full, bit1 = empty, bits[8+FIFO_AW:8] = occupancy count (0..depth), other bits 0.
  - 2, 3: reserved, read 0, writes ignored (see optional feature).
- Unmapped accesses: reads return 0 with `mem_valid` pulsed; writes are ignored. No error is signalled.
- `mem_valid`:
  - Pulses exactly once per accepted read, one cycle later.
  - Never asserted for writes.
  - Back-to-back reads give back-to-back pulses.
- `mem_ready` = !fifo_full.
  - Conservative: it deasserts for all accesses while the FIFO is full, even if a pop occurs the same cycle.
  - A push presented while full (protocol violation) is dropped; count is unchanged.
- TX FIFO:
  - Circular buffer of depth 2^FIFO_AW with pointers of FIFO_AW+1 bits; full/empty are derived from the MSB compare.
  - Pop on `tx_valid && tx_ready`.
  - Simultaneous push and pop when non-empty and non-full: count is unchanged, order is preserved.
  - Push while empty: `tx_valid` rises the next cycle (registered head).
  - Pointers wrap modulo 2^(FIFO_AW+1).
- Reset (`rst`=0 at posedge):
  - `mem_rdata`=0, `mem_valid`=0, `tx_valid`=0, `tx_data`=0, FIFO pointers=0, count=0.
  - `mem_ready`=1 in the cycle after reset.
  - Any read accepted in the reset cycle produces no `mem_valid`.
  - RAM contents are not cleared.
- No internal state machine beyond the read-response register and the FIFO. Every request completes in a single acceptance cycle.

Optional Feature:
- DMEM_BUS_STAT_EN
- Defined:
  - Two 32-bit counters, wrapping, cleared on reset: read count at MMIO offset 2 and write count at offset 3.
  - Each accepted read or write increments its counter (unmapped accesses included).
  - A write of any value to offset 2 or 3 clears that counter (the clear takes priority over the increment).
- Undefined: offsets 2 and 3 read 0 and the counter logic is absent.

Test Plan:
- Write 0xDEADBEEF to 0x100 with `we`=4'b1111, then write `we`=4'b0010 with `wdata`=0x00005500, then read 0x100 -> `mem_rdata`=0xDEAD55EF with `mem_valid` pulsed exactly one cycle after acceptance.
- Three back-to-back reads of 0x0, 0x4, 0x8 preloaded with 1, 2, 3 -> `mem_valid` high for 3 consecutive cycles returning 1, 2, 3 in order.
- `tx_ready`=0; push 16 bytes 0x41..0x50 to MMIO_BASE -> `mem_ready`=0 after the 16th push and STATUS read (once re-enabled) shows count=16, full=1. Raise `tx_ready` -> bytes drain 0x41..0x50 in order, `mem_ready` returns to 1, and STATUS reads empty=1, count=0.
- FIFO holding 3 entries, `tx_ready`=1, push each cycle for 20 cycles -> count stays 3, no loss or reorder, and pointers wrap cleanly.
- Read from unmapped 0x4000_0000 -> `mem_valid`=1 with `mem_rdata`=0; write there -> no RAM or FIFO change.
- Assert `rst`=0 for one cycle with the FIFO at 5 entries and a read accepted the same edge -> no `mem_valid`, `tx_valid`=0, and STATUS then reads count=0 while earlier RAM data is intact. With DMEM_BUS_STAT_EN: 4 reads and 2 writes -> offset 2 reads 4 (the reading itself counts after), offset 3 reads 2.

Source files
------------

// File: rtl/dmem_bus.sv
// Data-side memory subsystem: byte-lane RAM plus an MMIO TX FIFO feeding a UART.
// Define DMEM_BUS_STAT_EN to add read/write access counters at MMIO offsets 2 and 3.
module dmem_bus #(
    parameter int          RAM_AW    = 14,
    parameter int          FIFO_AW   = 4,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_oe,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_we,
    output logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic        mem_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int RAM_WORDS  = 1 << (RAM_AW - 2);
    localparam int FIFO_DEPTH = 1 << FIFO_AW;
    localparam int PW         = FIFO_AW + 1;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_STATUS = 2'd1,
        REG_RDCNT  = 2'd2,
        REG_WRCNT  = 2'd3
    } mmio_reg_e;

    logic [31:0]       ram_q  [RAM_WORDS];
    logic [7:0]        fifo_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              mem_valid_q, mem_valid_d;

    logic              is_rd, is_wr;
    logic              hit_ram, hit_mmio;
    logic [RAM_AW-3:0] word_idx;
    mmio_reg_e         mmio_reg;
    logic [PW-1:0]     count;
    logic              fifo_full, fifo_empty;
    logic              push, pop;
    logic [31:0]       status;
    logic [31:0]       rdata_sel;
    logic              unused_addr_bits;

`ifdef DMEM_BUS_STAT_EN
    logic [31:0]       rd_cnt_q, rd_cnt_d;
    logic [31:0]       wr_cnt_q, wr_cnt_d;
`endif

    assign unused_addr_bits = ^mem_addr[1:0];

    assign hit_ram  = (mem_addr[31:RAM_AW] == '0);
    assign hit_mmio = (mem_addr[31:4] == MMIO_BASE[31:4]);
    assign word_idx = mem_addr[RAM_AW-1:2];
    assign mmio_reg = mmio_reg_e'(mem_addr[3:2]);

    // Requests arriving while reset is held are discarded entirely.
    assign is_rd = rst && (mem_oe != '0) && (mem_we == '0);
    assign is_wr = rst && (mem_oe != '0) && (mem_we != '0);

    assign count      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

    assign push = is_wr && hit_mmio && (mmio_reg == REG_TXDATA) && mem_we[0] && !fifo_full;
    assign pop  = !fifo_empty && tx_ready;

    assign mem_ready = !fifo_full;
    assign tx_valid  = !fifo_empty;
    assign tx_data   = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q[FIFO_AW-1:0]];
    assign mem_rdata = mem_rdata_q;
    assign mem_valid = mem_valid_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        status            = '0;
        status[0]         = fifo_full;
        status[1]         = fifo_empty;
        status[8 +: PW]   = count;

        rdata_sel = '0;
        if (hit_ram) begin
            rdata_sel = ram_q[word_idx];
        end else if (hit_mmio) begin
            case (mmio_reg)
                REG_STATUS: rdata_sel = status;
`ifdef DMEM_BUS_STAT_EN
                REG_RDCNT:  rdata_sel = rd_cnt_q;
                REG_WRCNT:  rdata_sel = wr_cnt_q;
`endif
                default:    rdata_sel = '0;
            endcase
        end

        mem_valid_d = is_rd;
        mem_rdata_d = is_rd ? rdata_sel : mem_rdata_q;

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);

`ifdef DMEM_BUS_STAT_EN
        rd_cnt_d = rd_cnt_q + 32'(is_rd);
        wr_cnt_d = wr_cnt_q + 32'(is_wr);
        if (is_wr && hit_mmio && (mmio_reg == REG_RDCNT)) rd_cnt_d = '0;
        if (is_wr && hit_mmio && (mmio_reg == REG_WRCNT)) wr_cnt_d = '0;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_rdata_q <= '0;
            mem_valid_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
`ifdef DMEM_BUS_STAT_EN
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
`endif
        end else begin
            mem_rdata_q <= mem_rdata_d;
            mem_valid_q <= mem_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
`ifdef DMEM_BUS_STAT_EN
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
`endif
        end
    end

    // NOTE: storage arrays carry no reset; their contents survive rst and map cleanly to RAM.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (is_wr && hit_ram && mem_we[k]) begin
                ram_q[word_idx][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
        end
        if (push) begin
            fifo_q[wr_ptr_q[FIFO_AW-1:0]] <= mem_wdata[7:0];
        end
    end

endmodule

// File: tb/tb_dmem_bus.sv
// Directed self-checking bench for dmem_bus (RAM, MMIO TX FIFO, reset, optional counters).
module tb_dmem_bus;

    localparam logic [31:0] MMIO = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [3:0]  mem_oe;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_bus dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_oe    (mem_oe),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_addr  = '0;
        mem_oe    = '0;
        mem_wdata = '0;
        mem_we    = '0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
        mem_addr  = addr;
        mem_wdata = data;
        mem_we    = we;
        mem_oe    = we;
        tick();
        idle();
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        mem_addr = addr;
        mem_oe   = 4'hF;
        mem_we   = '0;
        tick();
        idle();
        check({tag, "_valid"}, 32'(mem_valid), 32'd1);
        check(tag, mem_rdata, exp);
    endtask

    initial begin
        rst      = 1'b0;
        tx_ready = 1'b0;
        idle();
        repeat (2) tick();
        check("rst_valid",   32'(mem_valid), 32'd0);
        check("rst_rdata",   mem_rdata,      32'd0);
        check("rst_txvalid", 32'(tx_valid),  32'd0);
        check("rst_txdata",  32'(tx_data),   32'd0);
        rst = 1'b1;
        tick();
        check("post_rst_ready", 32'(mem_ready), 32'd1);

        // Full write, partial lane write, read-back with latency-1 single pulse.
        wr(32'h100, 32'hDEAD_BEEF, 4'b1111);
        wr(32'h100, 32'h0000_5500, 4'b0010);
        rd("rmw", 32'h100, 32'hDEAD_55EF);
        tick();
        check("rmw_pulse_end", 32'(mem_valid), 32'd0);

        // Back-to-back reads.
        wr(32'h0, 32'd1, 4'hF);
        wr(32'h4, 32'd2, 4'hF);
        wr(32'h8, 32'd3, 4'hF);
        for (int i = 0; i < 3; i++) begin
            mem_addr = 32'(4 * i);
            mem_oe   = 4'hF;
            mem_we   = '0;
            tick();
            check("b2b_valid", 32'(mem_valid), 32'd1);
            check("b2b_data",  mem_rdata,      32'(i + 1));
        end
        idle();
        tick();
        check("b2b_end", 32'(mem_valid), 32'd0);

        // RAM top word and first unmapped address above it.
        wr(32'h3FFC, 32'hA5A5_0F0F, 4'hF);
        rd("ram_top", 32'h3FFC, 32'hA5A5_0F0F);
        wr(32'h4000, 32'hFFFF_FFFF, 4'hF);
        rd("ram_no_alias", 32'h0, 32'd1);
        rd("unmapped_edge", 32'h4000, 32'd0);

        // Unmapped accesses.
        rd("ram_before_unm", 32'h100, 32'hDEAD_55EF);
        rd("unmapped_rd", 32'h4000_0000, 32'd0);
        wr(32'h4000_0100, 32'h1234_5678, 4'hF);
        wr(32'h8000_0010, 32'h0000_0077, 4'b0001);
        rd("unm_wr_ram", 32'h100, 32'hDEAD_55EF);
        rd("unm_wr_fifo", MMIO + 32'h4, 32'h0000_0002);
        rd("txdata_rd", MMIO, 32'd0);

        // Fill the FIFO to full with the UART stalled.
        for (int i = 0; i < 16; i++) begin
            wr(MMIO, 32'h41 + 32'(i), 4'b0001);
            if (i == 14) check("ready_at_15", 32'(mem_ready), 32'd1);
        end
        check("ready_full", 32'(mem_ready), 32'd0);
        wr(MMIO, 32'h99, 4'b0001);
        rd("status_full", MMIO + 32'h4, 32'h0000_1001);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain", 32'({tx_valid, tx_data}), 32'h141 + 32'(i));
            tick();
        end
        check("drain_empty", 32'(tx_valid), 32'd0);
        check("drain_ready", 32'(mem_ready), 32'd1);
        rd("status_empty", MMIO + 32'h4, 32'h0000_0002);

        // Steady push+pop with 3 entries resident; pointers wrap.
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr(MMIO, 32'h10 + 32'(i), 4'b0001);
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("stream", 32'({tx_valid, tx_data}), 32'h110 + 32'(i));
            mem_addr  = MMIO;
            mem_wdata = 32'h13 + 32'(i);
            mem_we    = 4'b0001;
            mem_oe    = 4'b0001;
            tick();
        end
        idle();
        tx_ready = 1'b0;
        rd("status_3", MMIO + 32'h4, 32'h0000_0300);
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stream_tail", 32'({tx_valid, tx_data}), 32'h124 + 32'(i));
            tick();
        end
        tx_ready = 1'b0;
        check("stream_empty", 32'(tx_valid), 32'd0);

        // Reset mid-traffic with 5 queued bytes and a read on the reset edge.
        for (int i = 0; i < 5; i++) wr(MMIO, 32'h61 + 32'(i), 4'b0001);
        rd("status_5", MMIO + 32'h4, 32'h0000_0500);
        mem_addr = 32'h100;
        mem_oe   = 4'hF;
        mem_we   = '0;
        rst      = 1'b0;
        tick();
        rst = 1'b1;
        idle();
        check("rst2_valid",   32'(mem_valid), 32'd0);
        check("rst2_rdata",   mem_rdata,      32'd0);
        check("rst2_txvalid", 32'(tx_valid),  32'd0);
        check("rst2_txdata",  32'(tx_data),   32'd0);
        check("rst2_ready",   32'(mem_ready), 32'd1);
        rd("rst2_status", MMIO + 32'h4, 32'h0000_0002);
        rd("rst2_ram", 32'h100, 32'hDEAD_55EF);
        rd("rst2_ram8", 32'h8, 32'd3);

`ifdef DMEM_BUS_STAT_EN
        rst = 1'b0;
        tick();
        rst = 1'b1;
        rd("st_r0", 32'h0, 32'd1);
        rd("st_r1", 32'h4, 32'd2);
        rd("st_r2", 32'h8, 32'd3);
        rd("st_r3", 32'h100, 32'hDEAD_55EF);
        wr(32'h200, 32'h5555_AAAA, 4'hF);
        wr(32'h4000_0000, 32'h1, 4'hF);
        rd("rd_cnt", MMIO + 32'h8, 32'd4);
        rd("wr_cnt", MMIO + 32'hC, 32'd2);
        wr(MMIO + 32'h8, 32'hFFFF_FFFF, 4'hF);
        rd("rd_cnt_clr", MMIO + 32'h8, 32'd0);
        rd("wr_cnt_3", MMIO + 32'hC, 32'd3);
        wr(MMIO + 32'hC, 32'h0, 4'hF);
        rd("wr_cnt_clr", MMIO + 32'hC, 32'd0);
`else
        rd("off2_zero", MMIO + 32'h8, 32'd0);
        rd("ram_nz", 32'h4, 32'd2);
        rd("off3_zero", MMIO + 32'hC, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
